// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the SPART/UART path
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int UART_DATA_BITS   = 8;
  localparam int UART_OS_RATE_DEF = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop synchronizer (resets to idle-high) with falling-edge strobe
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/receive.sv
// rtl/receive.sv - 8N1 UART receiver, 16x oversampled; RX_FERR_EN adds a sticky ferr output
module receive
  import uart_pkg::*;
#(
  parameter int OS_RATE = UART_OS_RATE_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_baud,
  input  logic                      rxd,
  input  logic                      rx_read,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rda,
  output logic                      overrun
`ifdef RX_FERR_EN
  ,
  output logic                      ferr
`endif
);

  localparam int                OSW      = $clog2(OS_RATE);
  localparam logic [OSW-1:0]    OS_MID   = OSW'(OS_RATE / 2 - 1);
  localparam logic [OSW-1:0]    OS_LAST  = OSW'(OS_RATE - 1);
  localparam logic [3:0]        BIT_LAST = 4'(UART_DATA_BITS - 1);

  logic rxs;
  logic rx_fall;

  rx_state_t                 state_q, state_d;
  logic [OSW-1:0]            os_cnt_q, os_cnt_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      rda_q, rda_d;
  logic                      ovr_q, ovr_d;
`ifdef RX_FERR_EN
  logic                      ferr_q, ferr_d;
`endif

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (rxd),
    .sync_o  (rxs),
    .fall_o  (rx_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      rda_q     <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef RX_FERR_EN
      ferr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rda_q     <= rda_d;
      ovr_q     <= ovr_d;
`ifdef RX_FERR_EN
      ferr_q    <= ferr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    rda_d     = rda_q;
    ovr_d     = ovr_q;
`ifdef RX_FERR_EN
    ferr_d    = ferr_q;
`endif

    // A completing frame later in this block overrides the read-clear.
    if (rx_read) begin
      rda_d = 1'b0;
      ovr_d = 1'b0;
`ifdef RX_FERR_EN
      ferr_d = 1'b0;
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d   = START;
          os_cnt_d  = '0;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (rx_baud) begin
          if (os_cnt_q == OS_MID) begin
            os_cnt_d = '0;
            state_d  = rxs ? IDLE : DATA;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (rx_baud) begin
          if (os_cnt_q == OS_LAST) begin
            shift_d   = {rxs, shift_q[UART_DATA_BITS-1:1]};
            os_cnt_d  = '0;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) state_d = STOP;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (rx_baud) begin
          if (os_cnt_q == OS_LAST) begin
            // Back to IDLE at the stop midpoint so a following start edge is caught.
            state_d  = IDLE;
            os_cnt_d = '0;
            if (rxs) begin
              data_d = shift_q;
              rda_d  = 1'b1;
              ovr_d  = rda_q && !rx_read;
            end
`ifdef RX_FERR_EN
            else begin
              data_d = shift_q;
              rda_d  = 1'b1;
              ovr_d  = rda_q && !rx_read;
              ferr_d = 1'b1;
            end
`endif
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_data = data_q;
  assign rda     = rda_q;
  assign overrun = ovr_q;
`ifdef RX_FERR_EN
  assign ferr    = ferr_q;
`endif

endmodule

// File: tb/tb_receive.sv
// tb/tb_receive.sv - directed self-checking bench for receive; build with RX_FERR_EN to cover ferr
module tb_receive;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_baud;
  logic       rxd;
  logic       rx_read;
  logic [7:0] rx_data;
  logic       rda;
  logic       overrun;
`ifdef RX_FERR_EN
  logic       ferr;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // One baud-enable cycle in every four clocks gives 64 clocks per bit.
  assign rx_baud = (cyc[1:0] == 2'd0);

  receive #(.OS_RATE(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx_baud (rx_baud),
    .rxd     (rxd),
    .rx_read (rx_read),
    .rx_data (rx_data),
    .rda     (rda),
    .overrun (overrun)
`ifdef RX_FERR_EN
    ,
    .ferr    (ferr)
`endif
  );

  // Start bit begins in cycle c0 (a baud cycle); the stop bit is sampled in
  // cycle c0+608 and rda/rx_data are visible from cycle c0+609.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, output int c0);
    while (cyc[1:0] != 2'd0) @(negedge clk);
    c0 = cyc;
    rxd = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (64) @(negedge clk);
    end
    rxd = stop_bit;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic finish_frame(input int c0);
    wait_to(c0 + 640);
    rxd = 1'b1;
  endtask

  task automatic pulse_read;
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rxd = 1'b1; rx_read = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (rda !== 1'b0) begin n_fail++; $display("FAIL reset_rda got %b exp 0", rda); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", rx_data); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", overrun); end
`ifdef RX_FERR_EN
    n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b exp 0", ferr); end
`endif
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (rda !== 1'b0) begin n_fail++; $display("FAIL idle_rda got %b exp 0", rda); end
  endtask

  task automatic test_basic;
    int c0;
    drive_frame(8'hA5, 1'b1, c0);
    wait_to(c0 + 608);
    n_checks++; if (rda !== 1'b0) begin n_fail++; $display("FAIL a5_rda_early got %b exp 0", rda); end
    @(negedge clk);
    n_checks++; if (rda !== 1'b1) begin n_fail++; $display("FAIL a5_rda got %b exp 1", rda); end
    n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL a5_data got %h exp a5", rx_data); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL a5_overrun got %b exp 0", overrun); end
    pulse_read();
    n_checks++; if (rda !== 1'b0) begin n_fail++; $display("FAIL a5_read_rda got %b exp 0", rda); end
    finish_frame(c0);
  endtask

  task automatic test_glitch;
    int c0;
    while (cyc[1:0] != 2'd0) @(negedge clk);
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (700) @(negedge clk);
    n_checks++; if (rda !== 1'b0) begin n_fail++; $display("FAIL glitch_rda got %b exp 0", rda); end
    drive_frame(8'h3C, 1'b1, c0);
    wait_to(c0 + 609);
    n_checks++; if (rda !== 1'b1) begin n_fail++; $display("FAIL 3c_rda got %b exp 1", rda); end
    n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL 3c_data got %h exp 3c", rx_data); end
    pulse_read();
    finish_frame(c0);
  endtask

  task automatic test_back_to_back;
    int c0;
    int c1;
    drive_frame(8'h11, 1'b1, c0);
    wait_to(c0 + 609);
    n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL b2b_first_data got %h exp 11", rx_data); end
    finish_frame(c0);
    drive_frame(8'h22, 1'b1, c1);
    wait_to(c1 + 609);
    n_checks++; if (rx_data !== 8'h22) begin n_fail++; $display("FAIL b2b_data got %h exp 22", rx_data); end
    n_checks++; if (rda !== 1'b1) begin n_fail++; $display("FAIL b2b_rda got %b exp 1", rda); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun got %b exp 1", overrun); end
    pulse_read();
    n_checks++; if (rda !== 1'b0) begin n_fail++; $display("FAIL b2b_read_rda got %b exp 0", rda); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_read_overrun got %b exp 0", overrun); end
    finish_frame(c1);
  endtask

  task automatic test_read_collision;
    int c0;
    int c1;
    drive_frame(8'h99, 1'b1, c0);
    finish_frame(c0);
    n_checks++; if (rda !== 1'b1) begin n_fail++; $display("FAIL col_pre_rda got %b exp 1", rda); end
    drive_frame(8'h7E, 1'b1, c1);
    wait_to(c1 + 608);
    pulse_read();
    n_checks++; if (rda !== 1'b1) begin n_fail++; $display("FAIL col_rda got %b exp 1", rda); end
    n_checks++; if (rx_data !== 8'h7E) begin n_fail++; $display("FAIL col_data got %h exp 7e", rx_data); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL col_overrun got %b exp 0", overrun); end
    finish_frame(c1);
  endtask

  task automatic test_bad_stop;
    int c0;
    pulse_read();
    drive_frame(8'hFF, 1'b0, c0);
    wait_to(c0 + 609);
`ifdef RX_FERR_EN
    n_checks++; if (ferr !== 1'b1) begin n_fail++; $display("FAIL ferr_flag got %b exp 1", ferr); end
    n_checks++; if (rda !== 1'b1) begin n_fail++; $display("FAIL ferr_rda got %b exp 1", rda); end
    n_checks++; if (rx_data !== 8'hFF) begin n_fail++; $display("FAIL ferr_data got %h exp ff", rx_data); end
    pulse_read();
    n_checks++; if (ferr !== 1'b0) begin n_fail++; $display("FAIL ferr_clear got %b exp 0", ferr); end
`else
    n_checks++; if (rda !== 1'b0) begin n_fail++; $display("FAIL badstop_rda got %b exp 0", rda); end
    n_checks++; if (rx_data !== 8'h7E) begin n_fail++; $display("FAIL badstop_data got %h exp 7e", rx_data); end
`endif
    finish_frame(c0);
    repeat (100) @(negedge clk);
    n_checks++; if (rda !== 1'b0) begin n_fail++; $display("FAIL badstop_after_rda got %b exp 0", rda); end
  endtask

  task automatic test_reset_midframe;
    int c0;
    int c1;
    logic [7:0] b = 8'h55;
    drive_frame(8'h5A, 1'b1, c0);
    finish_frame(c0);
    n_checks++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL rst_pre_data got %h exp 5a", rx_data); end
    while (cyc[1:0] != 2'd0) @(negedge clk);
    rxd = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (64) @(negedge clk);
    end
    rxd = b[4];
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    n_checks++; if (rda !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rda got %b exp 0", rda); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data got %h exp 00", rx_data); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_mid_overrun got %b exp 0", overrun); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (700) @(negedge clk);
    n_checks++; if (rda !== 1'b0) begin n_fail++; $display("FAIL rst_tail_rda got %b exp 0", rda); end
    drive_frame(8'h0F, 1'b1, c1);
    wait_to(c1 + 609);
    n_checks++; if (rda !== 1'b1) begin n_fail++; $display("FAIL 0f_rda got %b exp 1", rda); end
    n_checks++; if (rx_data !== 8'h0F) begin n_fail++; $display("FAIL 0f_data got %h exp 0f", rx_data); end
    finish_frame(c1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_back_to_back();
    test_read_collision();
    test_bad_stop();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
